// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the SISO loopback controller.
// Holds the FSM state enum, default sizes and counter-width function.
package siso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Wide enough to reach WIDTH+DEPTH without wrapping.
  function automatic int cnt_w(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// Shift-cycle counter for the SISO loopback controller.
// Ports: clk, rst_n, i_clr, i_inc, o_cnt (cycle index), o_last (index WIDTH+DEPTH-1).
module siso_bit_counter
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cnt_w(WIDTH, DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/siso_loopback_ctrl.sv
// Sends a parallel word MSB-first into an external SISO chain, flushes it
// with zeros and reassembles the returned bits, flagging a match.
// Ports: clk, rst_n, start, data_in -> ready, busy, done, sin, shift_en;
// sout (chain output) -> rx_data, match.
module siso_loopback_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             sin,
  output logic             shift_en,
  input  logic             sout,
  output logic [WIDTH-1:0] rx_data,
  output logic             match
);

  localparam int CW = cnt_w(WIDTH, DEPTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_txsh;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_sin;
  logic             r_shift_en;
  logic             r_match;

  logic [CW-1:0]    w_cnt;
  logic             w_last;
  logic             w_accept;
  logic             w_shifting;
  logic             w_capture;
  logic [WIDTH:0]   w_rx_cat;
  logic [WIDTH:0]   w_tx_cat;
  logic [WIDTH:0]   w_ld_cat;
  logic [WIDTH-1:0] w_rx_next;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_shifting = (r_state == SHIFT);
  // Chain output carries our bits from index DEPTH on.
  assign w_capture  = w_shifting && (w_cnt >= CW'(DEPTH));

  assign w_rx_cat  = {r_rx, sout};
  assign w_rx_next = w_rx_cat[WIDTH-1:0];
  // Zeros shifted in behind the word give the flush for free.
  assign w_tx_cat  = {r_txsh, 1'b0};
  assign w_ld_cat  = {data_in, 1'b0};

  siso_bit_counter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_inc  (w_shifting),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx       <= '0;
      r_txsh     <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sin      <= 1'b0;
      r_shift_en <= 1'b0;
      r_match    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_tx       <= data_in;
            r_txsh     <= w_ld_cat[WIDTH-1:0];
            r_sin      <= data_in[WIDTH-1];
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_match    <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_shift_en <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_txsh <= w_tx_cat[WIDTH-1:0];
          if (w_capture) begin
            r_rx <= w_rx_next;
          end
          if (w_last) begin
            // Last index always lies in the capture window.
            r_sin      <= 1'b0;
            r_busy     <= 1'b0;
            r_shift_en <= 1'b0;
            r_done     <= 1'b1;
            r_rx_data  <= w_rx_next;
            r_match    <= (w_rx_next == r_tx);
            r_state    <= DONE;
          end else begin
            r_sin <= r_txsh[WIDTH-1];
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sin      = r_sin;
  assign shift_en = r_shift_en;
  assign rx_data  = r_rx_data;
  assign match    = r_match;

endmodule

// File: doc/siso_loopback_ctrl.md
# siso_loopback_ctrl

Sequencer that drives an external free-running serial-in/serial-out shift register of DEPTH stages. It accepts a parallel WIDTH-bit word, drives it onto the register's serial input MSB first, and flushes the chain with zeros. It collects the delayed serial output back into a parallel word and flags whether the returned word matches the sent one. It sits between a parallel requester (CPU or test sequencer) and the SISO chain, and is used for chain loopback checking and timed serial transfers.

## Interface
- WIDTH, 8, bits per transferred word (≥1)
- DEPTH, 4, number of stages in the attached SISO register (≥1)
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; accepted only when ready=1
- data_in  input  WIDTH  word to send; sampled on the accepting edge
- ready  output  1  controller idle, start will be accepted
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse; rx_data/match valid
- sin  output  1  registered drive to the SISO register serial input
- shift_en  output  1  high during every shifting cycle, for enable-capable registers
- sout  input  1  serial output of the SISO register
- rx_data  output  WIDTH  word reassembled from sout, MSB first
- match  output  1  rx_data == transmitted word; valid with done, held until next accept

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. If start=1 at an edge, latch data_in into tx_reg, clear the counter and rx shift register, and go to SHIFT.
- SHIFT: runs for exactly WIDTH+DEPTH cycles, indexed i = 0..WIDTH+DEPTH-1 by the counter.
  - sin = tx_reg[WIDTH-1-i] for i < WIDTH; sin = 0 for i ≥ WIDTH (flush).
  - shift_en=1 and busy=1 throughout.
  - Capture: for i = DEPTH..DEPTH+WIDTH-1, sout is shifted into the LSB of rx_reg at the edge ending cycle i. Bits are shifted left, so the first returned bit ends up as the MSB.
  - At the edge ending i = WIDTH+DEPTH-1, go to DONE.
- DONE: lasts one cycle. done=1, busy=0, ready=0, shift_en=0, sin=0. rx_data=rx_reg and match = (rx_reg == tx_reg) are registered and held until the next accept. The state then returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE. It is not queued, so a held start is accepted in the first IDLE cycle.
- Counter width: $clog2(WIDTH+DEPTH+1). It never wraps within a transfer.
- sout is not synchronised; the SISO register shares clk.

## Timing
- Reset (rst_n=0 at an edge): the state goes to IDLE. ready=1. busy=0, done=0, sin=0, shift_en=0, rx_data=0, match=0.
- Reset mid-SHIFT aborts the transfer: no done pulse, and all outputs take their reset values at that edge. The external chain still holds stale bits; the flush of the next transfer clears them.
- Latency: accept at edge 0; SHIFT occupies cycles 0..WIDTH+DEPTH-1; done is high in cycle WIDTH+DEPTH; ready returns in cycle WIDTH+DEPTH+1.
- Minimum start-to-start spacing: WIDTH+DEPTH+2 cycles.
- Bit driven in cycle i appears on sout in cycle i+DEPTH (ideal chain).
- If start and rst_n=0 occur together, reset wins.

## Structure
- Package siso_ctrl_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - default WIDTH/DEPTH localparams
  - function computing the counter width
- Sub-module siso_bit_counter: synchronous clear, increment enable, and terminal flag at WIDTH+DEPTH-1. Instantiated once.
- FSM, tx_reg, rx_reg and output registers live in the top module.

## Test plan
- Ideal 4-stage chain, WIDTH=8, start with data_in=0xA5 → sin carries 1,0,1,0,0,1,0,1,0,0,0,0 in cycles 0..11. done in cycle 12, rx_data=0xA5, match=1.
- sout tied to 0, data_in=0x3C → done in cycle 12, rx_data=0x00, match=0.
- start pulsed at cycles 3 and 12 during a transfer of 0xFF → both ignored. A single done, rx_data=0xFF. ready returns in cycle 13.
- rst_n low at cycle 5 of a 0x81 transfer → next edge: busy=0, sin=0, shift_en=0, rx_data=0, no done. A following 0x81 transfer returns match=1.
- start held high continuously, data_in=0x5A then 0xC3 → second accept in cycle 13, second done in cycle 26 with rx_data=0xC3, match=1.
- Parameters WIDTH=4, DEPTH=1, data_in=0xB → done in cycle 5, rx_data=0xB, match=1.
